// File: rtl/cpu_clock_pkg.sv
// -----------------------------------------------------------------------------
// cpu_clock_pkg
// Shared types for the CPU clock controller slice.
//   mode_t  : operator-selected clocking mode (mode input encoding)
//   state_t : controller state machine encoding
//   mode_wants_step : true for the modes that request single-stepping
// -----------------------------------------------------------------------------
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STEP   = 2'b01,
    RUN_BP = 2'b10,
    RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_STEP   = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  // The reserved encoding behaves exactly like STEP.
  function automatic logic mode_wants_step(input mode_t m);
    return (m == STEP) || (m == RSVD);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises a raw active-low push-button and debounces it. The debounced
// level starts released (1); a new level is accepted only after CYCLES
// consecutive synchronised samples that differ from the current level.
// A one-clock press pulse is produced when the accepted level goes 1 -> 0.
//
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-high reset (drops any pending press)
//   key_n  in   raw active-low key, asynchronous to clock
//   press  out  one-clock pulse on each accepted press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // Stage p0/p1: two-flop synchroniser, parked at the released level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce counter. Any sample equal to the accepted level
  // restarts the count, so only an unbroken run of CYCLES differing
  // samples moves the level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= sync_p1;
          stable_cnt <= '0;
          press      <= ~sync_p1;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
// Generates a single-cycle clock enable for a soft CPU. In RUN the enable
// follows a programmable divider tap; in STEP each debounced key press
// issues one enable; RUN_BP runs until pc hits bp_addr and then halts.
// While HALTED a key press still single-steps, and resume leaves HALTED.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   mode[1:0]    in   00 RUN, 01 STEP, 10 RUN_BP, 11 behaves as STEP
//   div_sel      in   divider tap; one tick every 2^(div_sel+1) clocks
//   step_n       in   raw active-low step key
//   resume       in   one-cycle pulse that leaves HALTED
//   pc           in   current CPU program counter
//   bp_addr      in   breakpoint address (RUN_BP only)
//   cpu_en       out  registered one-cycle CPU clock enable
//   halted       out  high while HALTED
//   cycle_count  out  number of cpu_en pulses issued (wraps at 2^32)
// -----------------------------------------------------------------------------
module cpu_clock_ctrl
  import cpu_clock_pkg::*;
#(
  parameter int DIV_WIDTH       = 24,
  parameter int PC_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic [$clog2(DIV_WIDTH)-1:0] div_sel,
  input  logic                         step_n,
  input  logic                         resume,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic [PC_WIDTH-1:0]          bp_addr,
  output logic                         cpu_en,
  output logic                         halted,
  output logic [31:0]                  cycle_count
);

  localparam int SEL_W = $clog2(DIV_WIDTH);

  // Tap selects beyond the divider width clamp to the top bit.
  function automatic int sat_sel(input logic [SEL_W-1:0] sel);
    if (int'(sel) >= DIV_WIDTH) begin
      return DIV_WIDTH - 1;
    end
    return int'(sel);
  endfunction

  mode_t                mode_v;
  state_t               state;
  state_t               state_nx;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] tap_mask;
  logic                 tick;
  logic                 press;
  logic                 want_step;
  logic                 bp_armed;
  logic                 bp_hit;
  logic                 en_nx;

  assign mode_v    = mode_t'(mode);
  assign want_step = mode_wants_step(mode_v);
  assign bp_hit    = (mode_v == RUN_BP) && bp_armed && (pc == bp_addr);
  assign halted    = (state == S_HALTED);

  key_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock  (clock),
    .reset  (reset),
    .key_n  (step_n),
    .press  (press)
  );

  // Free-running divider; wraps naturally at 2^DIV_WIDTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Tick when every divider bit from 0 up to the tap is set: bits above the
  // tap are forced to 1 before the AND-reduce.
  always_comb begin
    tap_mask = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      tap_mask[i] = (i <= sat_sel(div_sel));
    end
  end

  assign tick = &(div_cnt | ~tap_mask);

  // Next-state and enable decision. A state change requested by mode or
  // resume takes priority over a press in the same clock, which is dropped.
  // Leaving RUN for STEP still honours the tick seen in RUN; only the
  // breakpoint suppresses it. A simultaneous resume blocks the breakpoint.
  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    case (state)
      S_RUN: begin
        if (want_step) begin
          state_nx = S_STEP;
          en_nx    = tick;
        end else if (bp_hit && !resume) begin
          state_nx = S_HALTED;
        end else begin
          en_nx = tick;
        end
      end
      S_STEP: begin
        if (!want_step) begin
          state_nx = S_RUN;
        end else begin
          en_nx = press;
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_nx = want_step ? S_STEP : S_RUN;
        end else begin
          en_nx = press;
        end
      end
      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  // Registered outputs, state and breakpoint arming. bp_armed re-arms only
  // once pc has moved off bp_addr, so a resume at the breakpoint does not
  // immediately halt again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
      bp_armed    <= 1'b1;
    end else begin
      state  <= state_nx;
      cpu_en <= en_nx;
      if (en_nx) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (resume) begin
        bp_armed <= 1'b0;
      end else if (pc != bp_addr) begin
        bp_armed <= 1'b1;
      end
    end
  end

endmodule
